// File: rtl/mem_access_unit_if.sv
// Instruction encodings and the execute / data-bus / write-back signal bundle
// that mem_access_unit sits in the middle of.
package mem_access_unit_pkg;
    localparam logic [5:0] INSTR_ADD = 6'd1;
    localparam logic [5:0] INSTR_LB  = 6'd16;
    localparam logic [5:0] INSTR_LH  = 6'd17;
    localparam logic [5:0] INSTR_LW  = 6'd18;
    localparam logic [5:0] INSTR_LBU = 6'd19;
    localparam logic [5:0] INSTR_LHU = 6'd20;
    localparam logic [5:0] INSTR_SB  = 6'd24;
    localparam logic [5:0] INSTR_SH  = 6'd25;
    localparam logic [5:0] INSTR_SW  = 6'd26;
endpackage

interface mem_access_unit_if;
    logic        valid_in;
    logic [5:0]  instr_id;
    logic [31:0] mem_addr;
    logic [31:0] store_data;
    logic [31:0] exec_result;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        flush;
    logic        stall_out;
    logic        dmem_req;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd_addr;
    logic        wb_rd_we;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic        exc_is_store;

    modport slave (
        input  valid_in, instr_id, mem_addr, store_data, exec_result, rd_addr, rd_we, flush,
               dmem_ready, dmem_rvalid, dmem_rdata,
        output stall_out, dmem_req, dmem_addr, dmem_wdata, dmem_wstrb,
               wb_valid, wb_rd_addr, wb_rd_we, wb_data, exc_valid, exc_is_store
    );

    modport master (
        output valid_in, instr_id, mem_addr, store_data, exec_result, rd_addr, rd_we, flush,
               dmem_ready, dmem_rvalid, dmem_rdata,
        input  stall_out, dmem_req, dmem_addr, dmem_wdata, dmem_wstrb,
               wb_valid, wb_rd_addr, wb_rd_we, wb_data, exc_valid, exc_is_store
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory stage: passes ALU results through, runs one load/store at a time on a
// ready/rvalid data bus, and traps misaligned accesses before they reach the bus.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    mem_access_unit_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RD, S_DRAIN} state_t;
    state_t r_state, w_next;

    logic        w_is_load, w_is_store, w_is_half, w_is_word, w_misalign;
    logic        w_present, w_accept, w_alu, w_exc, w_wb_mem, w_r_store;
    logic [31:0] w_wdata, w_shifted, w_load;
    logic [3:0]  w_wstrb;

    logic [5:0]  r_op;
    logic [1:0]  r_addr_lo;
    logic [4:0]  r_rd_addr;
    logic        r_rd_we;
    logic [31:0] r_daddr, r_wdata;
    logic [3:0]  r_wstrb;

    logic        r_wb_valid, r_wb_rd_we, r_exc_valid, r_exc_is_store;
    logic [4:0]  r_wb_rd_addr;
    logic [31:0] r_wb_data;

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_is_half  = 1'b0;
        w_is_word  = 1'b0;
        case (bus.instr_id)
            INSTR_LB, INSTR_LBU: w_is_load = 1'b1;
            INSTR_LH, INSTR_LHU: begin w_is_load = 1'b1; w_is_half = 1'b1; end
            INSTR_LW:            begin w_is_load = 1'b1; w_is_word = 1'b1; end
            INSTR_SB:            w_is_store = 1'b1;
            INSTR_SH:            begin w_is_store = 1'b1; w_is_half = 1'b1; end
            INSTR_SW:            begin w_is_store = 1'b1; w_is_word = 1'b1; end
            default:             ;
        endcase
        w_misalign = (w_is_half & bus.mem_addr[0]) |
                     (w_is_word & (bus.mem_addr[1:0] != 2'b00));
    end

    // Store data is replicated across lanes; the strobes pick the real bytes.
    always_comb begin
        w_wdata = bus.store_data;
        w_wstrb = 4'b0000;
        if (w_is_store) begin
            if (w_is_word) begin
                w_wstrb = 4'b1111;
            end else if (w_is_half) begin
                w_wdata = {2{bus.store_data[15:0]}};
                w_wstrb = bus.mem_addr[1] ? 4'b1100 : 4'b0011;
            end else begin
                w_wdata = {4{bus.store_data[7:0]}};
                w_wstrb = 4'b0001 << bus.mem_addr[1:0];
            end
        end
    end

    assign w_present = (r_state == S_IDLE) && bus.valid_in && !bus.flush;
    assign w_accept  = w_present && (w_is_load || w_is_store) && !w_misalign;
    assign w_alu     = w_present && !(w_is_load || w_is_store);
    assign w_exc     = w_present && (w_is_load || w_is_store) && w_misalign;
    assign w_r_store = (r_wstrb != 4'b0000);

    assign w_shifted = bus.dmem_rdata >> {r_addr_lo, 3'b000};
    always_comb begin
        case (r_op)
            INSTR_LB:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            INSTR_LBU: w_load = {24'd0, w_shifted[7:0]};
            INSTR_LH:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            INSTR_LHU: w_load = {16'd0, w_shifted[15:0]};
            default:   w_load = w_shifted;
        endcase
    end

    // A flushed load already accepted by the bus still owes one rvalid: DRAIN eats it.
    always_comb begin
        w_next   = r_state;
        w_wb_mem = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_REQ;
            S_REQ: begin
                if (bus.dmem_ready) begin
                    if (w_r_store) begin
                        w_next   = S_IDLE;
                        w_wb_mem = !bus.flush;
                    end else begin
                        w_next = bus.flush ? S_DRAIN : S_WAIT_RD;
                    end
                end else if (bus.flush) begin
                    w_next = S_IDLE;
                end
            end
            S_WAIT_RD: begin
                if (bus.dmem_rvalid) begin
                    w_next   = S_IDLE;
                    w_wb_mem = !bus.flush;
                end else if (bus.flush) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: if (bus.dmem_rvalid) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= '0;
            r_addr_lo <= '0;
            r_rd_addr <= '0;
            r_rd_we   <= 1'b0;
            r_daddr   <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else if (w_accept) begin
            r_op      <= bus.instr_id;
            r_addr_lo <= bus.mem_addr[1:0];
            r_rd_addr <= bus.rd_addr;
            r_rd_we   <= bus.rd_we & w_is_load;
            r_daddr   <= {bus.mem_addr[31:2], 2'b00};
            r_wdata   <= w_wdata;
            r_wstrb   <= w_wstrb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid     <= 1'b0;
            r_wb_rd_addr   <= '0;
            r_wb_rd_we     <= 1'b0;
            r_wb_data      <= '0;
            r_exc_valid    <= 1'b0;
            r_exc_is_store <= 1'b0;
        end else begin
            r_wb_valid     <= w_alu | w_wb_mem;
            r_exc_valid    <= w_exc;
            r_exc_is_store <= w_exc & w_is_store;
            if (w_alu) begin
                r_wb_data    <= bus.exec_result;
                r_wb_rd_addr <= bus.rd_addr;
                r_wb_rd_we   <= bus.rd_we;
            end else if (w_exc) begin
                r_wb_data    <= bus.mem_addr;
                r_wb_rd_addr <= bus.rd_addr;
                r_wb_rd_we   <= 1'b0;
            end else if (w_wb_mem) begin
                r_wb_rd_addr <= r_rd_addr;
                r_wb_rd_we   <= r_rd_we & !w_r_store;
                if (r_state == S_WAIT_RD) r_wb_data <= w_load;
            end
        end
    end

    assign bus.stall_out    = !rst && ((r_state != S_IDLE) || w_accept);
    assign bus.dmem_req     = (r_state == S_REQ);
    assign bus.dmem_addr    = r_daddr;
    assign bus.dmem_wdata   = r_wdata;
    assign bus.dmem_wstrb   = r_wstrb;
    assign bus.wb_valid     = r_wb_valid;
    assign bus.wb_rd_addr   = r_wb_rd_addr;
    assign bus.wb_rd_we     = r_wb_rd_we;
    assign bus.wb_data      = r_wb_data;
    assign bus.exc_valid    = r_exc_valid;
    assign bus.exc_is_store = r_exc_is_store;
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: a byte-lane reference model predicts bus
// traffic, load results and traps; flush and reset corners are driven by hand.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_unit_if bus();
    mem_access_unit dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          is_mem, is_load, mis;
        logic [31:0] daddr, wdata, ld;
        logic [3:0]  wstrb;
    } exp_t;

    typedef struct {
        bit          req_seen, hold_ok, stall_first, timeout, exc_st, wb_we;
        int          wb_cnt, exc_cnt;
        logic [31:0] addr, wdata, wb_data;
        logic [3:0]  wstrb;
        logic [4:0]  wb_rd;
    } obs_t;

    logic [5:0] loads  [5] = '{INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU};
    logic [5:0] stores [3] = '{INSTR_SB, INSTR_SH, INSTR_SW};
    logic [5:0] wide   [5] = '{INSTR_LH, INSTR_LHU, INSTR_SH, INSTR_LW, INSTR_SW};

    // Reference: access size, lane offset and byte copies, no knowledge of the FSM.
    function automatic exp_t model(input logic [5:0] op, input logic [31:0] addr, sd, rdata);
        exp_t e;
        int size, off;
        bit sgn;
        e = '{default: 0};
        size = 0; sgn = 0;
        case (op)
            INSTR_LB:  begin size = 1; sgn = 1; e.is_load = 1; end
            INSTR_LH:  begin size = 2; sgn = 1; e.is_load = 1; end
            INSTR_LW:  begin size = 4; e.is_load = 1; end
            INSTR_LBU: begin size = 1; e.is_load = 1; end
            INSTR_LHU: begin size = 2; e.is_load = 1; end
            INSTR_SB:  size = 1;
            INSTR_SH:  size = 2;
            INSTR_SW:  size = 4;
            default:   size = 0;
        endcase
        e.is_mem = (size != 0);
        off = int'(addr[1:0]);
        e.daddr = addr - 32'(off);
        if (e.is_mem) e.mis = (off % size) != 0;
        if (e.is_mem && !e.is_load && !e.mis)
            for (int k = 0; k < 4; k++) begin
                e.wdata[8*k +: 8] = sd[8*(k % size) +: 8];
                if (k >= off && k < off + size) e.wstrb[k] = 1'b1;
            end
        if (e.is_load && !e.mis) begin
            for (int i = 0; i < size; i++) e.ld[8*i +: 8] = rdata[8*(off+i) +: 8];
            if (sgn && e.ld[8*size-1])
                for (int i = size; i < 4; i++) e.ld[8*i +: 8] = 8'hFF;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic present(input logic [5:0] op, input logic [31:0] addr, sd, exr,
                           input logic [4:0] rd, input logic we);
        bus.instr_id = op; bus.mem_addr = addr; bus.store_data = sd;
        bus.exec_result = exr; bus.rd_addr = rd; bus.rd_we = we; bus.valid_in = 1'b1;
    endtask

    // Presents one op for one cycle and plays the bus slave until the unit idles.
    task automatic run_op(input logic [5:0] op, input logic [31:0] addr, sd, exr, rdata,
                          input logic [4:0] rd, input logic we, input int rdy_dly, rv_dly,
                          input bit tail, output obs_t o);
        int wcnt, rwait;
        bit done;
        o = '{default: 0}; o.hold_ok = 1; wcnt = 0; rwait = -1; done = 0;
        present(op, addr, sd, exr, rd, we);
        #1 o.stall_first = bus.stall_out;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            if (bus.wb_valid) begin
                o.wb_cnt++; o.wb_data = bus.wb_data; o.wb_rd = bus.wb_rd_addr; o.wb_we = bus.wb_rd_we;
            end
            if (bus.exc_valid) begin
                o.exc_cnt++; o.exc_st = bus.exc_is_store; o.wb_data = bus.wb_data;
            end
            if (rwait >= 0) begin
                if (rwait == rv_dly) begin
                    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = rdata; rwait = -1;
                end else rwait++;
            end
            if (bus.dmem_req) begin
                if (!o.req_seen) begin
                    o.req_seen = 1; o.addr = bus.dmem_addr; o.wdata = bus.dmem_wdata; o.wstrb = bus.dmem_wstrb;
                end else if ({bus.dmem_addr, bus.dmem_wdata, bus.dmem_wstrb} !== {o.addr, o.wdata, o.wstrb})
                    o.hold_ok = 0;
                if (wcnt == rdy_dly) begin
                    bus.dmem_ready = 1'b1;
                    if (bus.dmem_wstrb == 4'b0000) rwait = 0;
                end
                wcnt++;
            end
            if (!bus.stall_out && !bus.dmem_ready && !bus.dmem_rvalid && rwait < 0) done = 1;
            else begin
                tick();
                bus.dmem_ready = 1'b0; bus.dmem_rvalid = 1'b0;
            end
        end
        o.timeout = !done;
        if (tail) begin
            tick();
            if (bus.wb_valid) o.wb_cnt++;
            if (bus.exc_valid) o.exc_cnt++;
        end
    endtask

    task automatic test_reset();
        present(INSTR_LW, 32'h100, 32'h0, 32'h0, 5'd1, 1'b1);
        repeat (2) tick();
        n_tests++; if (bus.stall_out !== 1'b0) begin n_fail++; $display("FAIL rst_stall got=%b exp=0", bus.stall_out); end
        n_tests++; if (bus.dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%b exp=0", bus.dmem_req); end
        n_tests++; if ({bus.wb_valid, bus.exc_valid, bus.exc_is_store, bus.wb_rd_we} !== 4'b0) begin
            n_fail++; $display("FAIL rst_flags got=%b exp=0000", {bus.wb_valid, bus.exc_valid, bus.exc_is_store, bus.wb_rd_we}); end
        n_tests++; if ({bus.wb_data, bus.dmem_addr, bus.dmem_wstrb} !== '0) begin
            n_fail++; $display("FAIL rst_data got=%h/%h/%h exp=0", bus.wb_data, bus.dmem_addr, bus.dmem_wstrb); end
        bus.valid_in = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_alu();
        obs_t o;
        exp_t e;
        logic [5:0] op;
        logic [31:0] exr;
        logic [4:0] rd;
        logic we;
        run_op(INSTR_ADD, 32'h0, 32'h0, 32'h1234, 32'h0, 5'd5, 1'b1, 0, 0, 1, o);
        n_tests++; if (o.wb_cnt !== 1) begin n_fail++; $display("FAIL alu_wbcnt got=%0d exp=1", o.wb_cnt); end
        n_tests++; if (o.wb_data !== 32'h1234 || o.wb_rd !== 5'd5) begin
            n_fail++; $display("FAIL alu_data got=%h/r%0d exp=1234/r5", o.wb_data, o.wb_rd); end
        n_tests++; if (o.stall_first !== 1'b0 || o.req_seen !== 1'b0) begin
            n_fail++; $display("FAIL alu_stall got=%b/%b exp=0/0", o.stall_first, o.req_seen); end
        for (int i = 0; i < 6; i++) begin
            op = 6'($urandom_range(0, 63));
            e = model(op, 32'h0, 32'h0, 32'h0);
            if (e.is_mem) op = INSTR_ADD;
            exr = $urandom; rd = 5'($urandom); we = 1'($urandom);
            run_op(op, $urandom, $urandom, exr, 32'h0, rd, we, 0, 0, 1, o);
            n_tests++; if (o.wb_cnt !== 1 || o.wb_data !== exr || o.wb_rd !== rd || o.wb_we !== we) begin
                n_fail++; $display("FAIL alu_rand op=%0d got=%0d/%h/%0d/%b exp=1/%h/%0d/%b",
                                   op, o.wb_cnt, o.wb_data, o.wb_rd, o.wb_we, exr, rd, we); end
        end
    endtask

    task automatic test_load();
        obs_t o;
        exp_t e;
        logic [5:0] op;
        logic [31:0] addr, rdata;
        logic [4:0] rd;
        run_op(INSTR_LB, 32'h103, 32'h0, 32'h0, 32'h80FFFFFF, 5'd7, 1'b1, 2, 1, 1, o);
        n_tests++; if (o.addr !== 32'h100 || o.wstrb !== 4'b0000) begin
            n_fail++; $display("FAIL lb_bus got=%h/%b exp=00000100/0000", o.addr, o.wstrb); end
        n_tests++; if (o.wb_cnt !== 1 || o.wb_data !== 32'hFFFFFF80 || o.wb_we !== 1'b1) begin
            n_fail++; $display("FAIL lb_data got=%0d/%h/%b exp=1/ffffff80/1", o.wb_cnt, o.wb_data, o.wb_we); end
        n_tests++; if (o.stall_first !== 1'b1 || o.hold_ok !== 1'b1 || o.timeout) begin
            n_fail++; $display("FAIL lb_hold got=%b/%b/%b exp=1/1/0", o.stall_first, o.hold_ok, o.timeout); end
        run_op(INSTR_LBU, 32'h103, 32'h0, 32'h0, 32'h80FFFFFF, 5'd7, 1'b1, 2, 1, 1, o);
        n_tests++; if (o.wb_data !== 32'h00000080) begin
            n_fail++; $display("FAIL lbu_data got=%h exp=00000080", o.wb_data); end
        for (int i = 0; i < 10; i++) begin
            op = loads[$urandom_range(0, 4)];
            addr = $urandom; rdata = $urandom; rd = 5'($urandom);
            e = model(op, addr, 32'h0, rdata);
            if (e.mis) begin addr[1:0] = 2'b00; e = model(op, addr, 32'h0, rdata); end
            run_op(op, addr, 32'h0, 32'h0, rdata, rd, 1'b1, $urandom_range(0, 3), $urandom_range(0, 3), 1, o);
            n_tests++; if (o.wb_cnt !== 1 || o.wb_data !== e.ld || o.wb_rd !== rd || o.addr !== e.daddr
                           || !o.hold_ok || o.exc_cnt !== 0) begin
                n_fail++; $display("FAIL ld_rand op=%0d a=%h got=%0d/%h/%0d/%h/%b exp=1/%h/%0d/%h/1",
                                   op, addr, o.wb_cnt, o.wb_data, o.wb_rd, o.addr, o.hold_ok, e.ld, rd, e.daddr); end
        end
    endtask

    task automatic test_store();
        obs_t o;
        exp_t e;
        logic [5:0] op;
        logic [31:0] addr, sd;
        run_op(INSTR_SH, 32'h202, 32'h0000ABCD, 32'h0, 32'h0, 5'd9, 1'b1, 1, 0, 1, o);
        n_tests++; if (o.wdata !== 32'hABCDABCD || o.wstrb !== 4'b1100 || o.addr !== 32'h200) begin
            n_fail++; $display("FAIL sh_bus got=%h/%b/%h exp=abcdabcd/1100/00000200", o.wdata, o.wstrb, o.addr); end
        n_tests++; if (o.wb_cnt !== 1 || o.wb_we !== 1'b0) begin
            n_fail++; $display("FAIL sh_wb got=%0d/%b exp=1/0", o.wb_cnt, o.wb_we); end
        for (int i = 0; i < 8; i++) begin
            op = stores[$urandom_range(0, 2)];
            addr = $urandom; sd = $urandom;
            e = model(op, addr, sd, 32'h0);
            if (e.mis) begin addr[1:0] = 2'b00; e = model(op, addr, sd, 32'h0); end
            run_op(op, addr, sd, 32'h0, 32'h0, 5'($urandom), 1'b1, $urandom_range(0, 3), 0, 1, o);
            n_tests++; if (o.wdata !== e.wdata || o.wstrb !== e.wstrb || o.addr !== e.daddr
                           || o.wb_cnt !== 1 || o.wb_we !== 1'b0 || !o.hold_ok) begin
                n_fail++; $display("FAIL st_rand op=%0d a=%h got=%h/%b/%h/%0d/%b exp=%h/%b/%h/1/0",
                                   op, addr, o.wdata, o.wstrb, o.addr, o.wb_cnt, o.wb_we, e.wdata, e.wstrb, e.daddr); end
        end
    endtask

    task automatic test_misalign();
        obs_t o;
        logic [5:0] op;
        logic [31:0] addr;
        bit st;
        run_op(INSTR_LW, 32'h301, 32'h0, 32'h0, 32'h0, 5'd2, 1'b1, 0, 0, 1, o);
        n_tests++; if (o.req_seen !== 1'b0 || o.stall_first !== 1'b0) begin
            n_fail++; $display("FAIL lw_mis_req got=%b/%b exp=0/0", o.req_seen, o.stall_first); end
        n_tests++; if (o.exc_cnt !== 1 || o.exc_st !== 1'b0 || o.wb_data !== 32'h301 || o.wb_cnt !== 0) begin
            n_fail++; $display("FAIL lw_mis_exc got=%0d/%b/%h/%0d exp=1/0/00000301/0", o.exc_cnt, o.exc_st, o.wb_data, o.wb_cnt); end
        for (int i = 0; i < 6; i++) begin
            op = wide[$urandom_range(0, 4)];
            addr = $urandom;
            if (op == INSTR_LW || op == INSTR_SW) addr[1:0] = 2'($urandom_range(1, 3));
            else addr[0] = 1'b1;
            st = (op == INSTR_SH || op == INSTR_SW);
            run_op(op, addr, $urandom, 32'h0, 32'h0, 5'($urandom), 1'b1, 0, 0, 1, o);
            n_tests++; if (o.exc_cnt !== 1 || o.exc_st !== st || o.wb_data !== addr || o.wb_cnt !== 0 || o.req_seen) begin
                n_fail++; $display("FAIL mis_rand op=%0d a=%h got=%0d/%b/%h/%0d/%b exp=1/%b/%h/0/0",
                                   op, addr, o.exc_cnt, o.exc_st, o.wb_data, o.wb_cnt, o.req_seen, st, addr); end
        end
    endtask

    task automatic test_flush();
        bit wb_seen;
        // Flushed ops presented in IDLE vanish: no wb, no trap, no bus request.
        present(INSTR_ADD, 32'h0, 32'h0, 32'h55, 5'd4, 1'b1); bus.flush = 1'b1;
        tick(); bus.valid_in = 1'b0; bus.flush = 1'b0;
        n_tests++; if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL fl_idle_alu got=%b exp=0", bus.wb_valid); end
        present(INSTR_LW, 32'h301, 32'h0, 32'h0, 5'd4, 1'b1); bus.flush = 1'b1;
        tick(); bus.valid_in = 1'b0; bus.flush = 1'b0;
        n_tests++; if (bus.exc_valid !== 1'b0) begin n_fail++; $display("FAIL fl_idle_mis got=%b exp=0", bus.exc_valid); end
        present(INSTR_LW, 32'h400, 32'h0, 32'h0, 5'd4, 1'b1); bus.flush = 1'b1;
        #1;
        n_tests++; if (bus.stall_out !== 1'b0) begin n_fail++; $display("FAIL fl_idle_stall got=%b exp=0", bus.stall_out); end
        tick(); bus.valid_in = 1'b0; bus.flush = 1'b0;
        n_tests++; if (bus.dmem_req !== 1'b0) begin n_fail++; $display("FAIL fl_idle_req got=%b exp=0", bus.dmem_req); end

        // Flush while waiting for read data: stall until the orphan rvalid, no wb.
        present(INSTR_LW, 32'h400, 32'h0, 32'h0, 5'd3, 1'b1);
        tick(); bus.valid_in = 1'b0;
        bus.dmem_ready = 1'b1; tick(); bus.dmem_ready = 1'b0;
        bus.flush = 1'b1; tick(); bus.flush = 1'b0;
        wb_seen = 0;
        for (int i = 0; i < 2; i++) begin
            n_tests++; if (bus.stall_out !== 1'b1) begin n_fail++; $display("FAIL fl_drain_stall c%0d got=%b exp=1", i, bus.stall_out); end
            if (bus.wb_valid) wb_seen = 1;
            tick();
        end
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = $urandom;
        tick(); bus.dmem_rvalid = 1'b0;
        if (bus.wb_valid) wb_seen = 1;
        n_tests++; if (wb_seen !== 1'b0 || bus.stall_out !== 1'b0) begin
            n_fail++; $display("FAIL fl_drain_end got=%b/%b exp=0/0", wb_seen, bus.stall_out); end

        // Flush in REQ without ready: request withdrawn next cycle.
        present(INSTR_LW, 32'h404, 32'h0, 32'h0, 5'd3, 1'b1);
        tick(); bus.valid_in = 1'b0; bus.flush = 1'b1;
        tick(); bus.flush = 1'b0;
        n_tests++; if ({bus.dmem_req, bus.stall_out, bus.wb_valid} !== 3'b000) begin
            n_fail++; $display("FAIL fl_req got=%b exp=000", {bus.dmem_req, bus.stall_out, bus.wb_valid}); end

        // Flush together with ready on a load: response still owed, so drain it.
        present(INSTR_LH, 32'h408, 32'h0, 32'h0, 5'd3, 1'b1);
        tick(); bus.valid_in = 1'b0; bus.flush = 1'b1; bus.dmem_ready = 1'b1;
        tick(); bus.flush = 1'b0; bus.dmem_ready = 1'b0;
        n_tests++; if (bus.stall_out !== 1'b1 || bus.dmem_req !== 1'b0) begin
            n_fail++; $display("FAIL fl_ld_rdy got=%b/%b exp=1/0", bus.stall_out, bus.dmem_req); end
        bus.dmem_rvalid = 1'b1; tick(); bus.dmem_rvalid = 1'b0;
        n_tests++; if (bus.wb_valid !== 1'b0 || bus.stall_out !== 1'b0) begin
            n_fail++; $display("FAIL fl_ld_rdy_end got=%b/%b exp=0/0", bus.wb_valid, bus.stall_out); end

        // Flush together with ready on a store: done, nothing written back.
        present(INSTR_SW, 32'h40C, 32'h1, 32'h0, 5'd3, 1'b1);
        tick(); bus.valid_in = 1'b0; bus.flush = 1'b1; bus.dmem_ready = 1'b1;
        tick(); bus.flush = 1'b0; bus.dmem_ready = 1'b0;
        n_tests++; if (bus.wb_valid !== 1'b0 || bus.stall_out !== 1'b0) begin
            n_fail++; $display("FAIL fl_st_rdy got=%b/%b exp=0/0", bus.wb_valid, bus.stall_out); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        present(INSTR_LW, 32'h500, 32'h0, 32'h0, 5'd6, 1'b1);
        tick(); bus.valid_in = 1'b0;
        n_tests++; if (bus.dmem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_pre got=%b exp=1", bus.dmem_req); end
        rst = 1'b1; #1;
        n_tests++; if (bus.dmem_req !== 1'b0 || bus.stall_out !== 1'b0) begin
            n_fail++; $display("FAIL rmid_req got=%b/%b exp=0/0", bus.dmem_req, bus.stall_out); end
        tick(); rst = 1'b0; tick();
        run_op(INSTR_ADD, 32'h0, 32'h0, 32'hCAFE, 32'h0, 5'd8, 1'b1, 0, 0, 1, o);
        n_tests++; if (o.wb_cnt !== 1 || o.wb_data !== 32'hCAFE) begin
            n_fail++; $display("FAIL rmid_after got=%0d/%h exp=1/0000cafe", o.wb_cnt, o.wb_data); end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        exp_t e;
        logic [5:0] op;
        logic [31:0] addr, sd, exr, rdata;
        logic [4:0] rd;
        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 2))
                0: op = loads[$urandom_range(0, 4)];
                1: op = stores[$urandom_range(0, 2)];
                default: op = INSTR_ADD;
            endcase
            addr = $urandom; sd = $urandom; exr = $urandom; rdata = $urandom; rd = 5'($urandom);
            e = model(op, addr, sd, rdata);
            run_op(op, addr, sd, exr, rdata, rd, 1'b1, $urandom_range(0, 2), $urandom_range(0, 2), 0, o);
            n_tests++;
            if (o.timeout) begin
                n_fail++; $display("FAIL b2b_timeout op=%0d a=%h", op, addr);
            end else if (!e.is_mem) begin
                if (o.wb_cnt !== 1 || o.wb_data !== exr) begin
                    n_fail++; $display("FAIL b2b_alu got=%0d/%h exp=1/%h", o.wb_cnt, o.wb_data, exr); end
            end else if (e.mis) begin
                if (o.exc_cnt !== 1 || o.wb_cnt !== 0 || o.wb_data !== addr || o.req_seen) begin
                    n_fail++; $display("FAIL b2b_mis op=%0d got=%0d/%0d/%h exp=1/0/%h", op, o.exc_cnt, o.wb_cnt, o.wb_data, addr); end
            end else if (e.is_load) begin
                if (o.wb_cnt !== 1 || o.wb_data !== e.ld || o.addr !== e.daddr) begin
                    n_fail++; $display("FAIL b2b_ld op=%0d a=%h got=%h/%h exp=%h/%h", op, addr, o.wb_data, o.addr, e.ld, e.daddr); end
            end else begin
                if (o.wb_cnt !== 1 || o.wdata !== e.wdata || o.wstrb !== e.wstrb) begin
                    n_fail++; $display("FAIL b2b_st op=%0d a=%h got=%h/%b exp=%h/%b", op, addr, o.wdata, o.wstrb, e.wdata, e.wstrb); end
            end
        end
    endtask

    initial begin
        bus.valid_in = 1'b0; bus.instr_id = '0; bus.mem_addr = '0; bus.store_data = '0;
        bus.exec_result = '0; bus.rd_addr = '0; bus.rd_we = 1'b0; bus.flush = 1'b0;
        bus.dmem_ready = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_misalign();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port valid_in, input, 1, an execute-stage result is present this cycle.
REQ-004 SHALL have port instr_id, input, 6, instruction ID encoded per instr_defines.vh (INSTR_LB/LH/LW/LBU/LHU/SB/SH/SW select memory ops).
REQ-005 SHALL have port mem_addr, input, 32, effective byte address from execute.
REQ-006 SHALL have port store_data, input, 32, forwarded rs2 value.
REQ-007 SHALL have port exec_result, input, 32, execute result for non-memory ops.
REQ-008 SHALL have port rd_addr, input, 5, destination register.
REQ-009 SHALL have port rd_we, input, 1, instruction writes rd.
REQ-010 SHALL have port flush, input, 1, synchronous kill of the in-flight or presented op.
REQ-011 SHALL have port stall_out, output, 1, upstream must hold its outputs.
REQ-012 SHALL have port dmem_req, output, 1, bus request.
REQ-013 SHALL have port dmem_addr, output, 32, word address: mem_addr[31:2], 2'b00.
REQ-014 SHALL have port dmem_wdata, output, 32, lane-replicated store data.
REQ-015 SHALL have port dmem_wstrb, output, 4, byte strobes; nonzero means write, zero means read.
REQ-016 SHALL have port dmem_ready, input, 1, bus accepts request this cycle.
REQ-017 SHALL have port dmem_rvalid, input, 1, read data valid.
REQ-018 SHALL have port dmem_rdata, input, 32, read data.
REQ-019 SHALL have port wb_valid, output, 1, registered one-cycle pulse: result for write-back.
REQ-020 SHALL have port wb_rd_addr, output, 5, registered destination.
REQ-021 SHALL have port wb_rd_we, output, 1, registered write enable; 0 for stores.
REQ-022 SHALL have port wb_data, output, 32, result; faulting address when exc_valid.
REQ-023 SHALL have ports exc_valid (output, 1, misalign trap pulse) and exc_is_store (output, 1, 1=store cause 6, 0=load cause 4).

Function
REQ-024 SHALL implement FSM IDLE, REQ, WAIT_RD, DRAIN; leaving IDLE occurs only on an accepted aligned memory op.
REQ-025 SHALL, in IDLE with valid_in and a non-memory op, register exec_result/rd_addr/rd_we to wb_* with wb_valid next cycle (1-cycle latency, no stall).
REQ-026 SHALL treat LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, as misaligned: no bus request, exc_valid=1 and wb_data=mem_addr next cycle, wb_valid=0.
REQ-027 SHALL, on an aligned memory op in IDLE, latch the op, address and data, go to REQ and hold dmem_req=1 with stable dmem_addr/wdata/wstrb until dmem_ready.
REQ-028 SHALL, on REQ with dmem_ready: for stores go to IDLE and pulse wb_valid next cycle with wb_rd_we=0; for loads go to WAIT_RD.
REQ-029 SHALL, on WAIT_RD with dmem_rvalid, go to IDLE and present the extracted load value on wb_data with wb_valid next cycle.
REQ-030 SHALL drive stores as: SB wdata={4{b}}, wstrb=1<<addr[1:0]; SH wdata={2{h}}, wstrb=0011 or 1100 by addr[1]; SW wdata as-is, wstrb=1111.
REQ-031 SHALL extract loads by shifting rdata right by 8*addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-032 SHALL drive stall_out = (state!=IDLE) OR (valid_in AND aligned memory op in IDLE AND NOT flush), and SHALL ignore valid_in while state!=IDLE.
REQ-033 SHALL, on flush: in IDLE discard the presented op (no wb/exc); in REQ drop dmem_req and go to IDLE; in WAIT_RD go to DRAIN; flush with a same-cycle dmem_ready for a load SHALL go to DRAIN, and for a store SHALL go to IDLE with no wb_valid.
REQ-034 SHALL, in DRAIN, discard data on dmem_rvalid, go to IDLE, emit no wb_valid, and keep stall_out=1.

Reset
REQ-035 SHALL, while rst=1, force IDLE and all outputs (stall_out, dmem_*, wb_*, exc_*) to 0 immediately, including mid-transaction; the bus side discards any pending response.

Verification
REQ-036 ADD r5 exec_result=0x1234 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd_addr=5, stall_out never 1.
REQ-037 LB addr=0x103, dmem_ready after 2 cycles, rdata=0x80FFFFFF -> dmem_addr=0x100, wstrb=0, wb_data=0xFFFFFF80; with LBU wb_data=0x00000080.
REQ-038 SH addr=0x202, data=0xABCD -> dmem_wdata=0xABCDABCD, wstrb=1100, wb_valid=1 with wb_rd_we=0.
REQ-039 LW addr=0x301 -> no dmem_req, exc_valid=1, exc_is_store=0, wb_data=0x301.
REQ-040 LW accepted, flush in WAIT_RD, rvalid 3 cycles later -> no wb_valid, stall_out=1 until rvalid; rst asserted in REQ -> dmem_req=0 same cycle.
